pe2_req_drain: RTL
==================

// Module: pe2_req_drain
// PURPOSE
//  - Pending-request register feeding a 2-lowest-set-bit priority encoder; drains up to 2 requests/cycle.
//  - Upstream sources OR new request bits into a WIDTH-bit pending vector.
//  - Downstream sees lane0 = lowest pending bit and lane1 = second-lowest pending bit, each with valid/ready.
//  - A bit clears only when its lane handshake completes.
//  - Sits between request producers (e.g. wakeup/ready logic) and a 2-wide issue/select consumer.
// PARAMETERS
//  - WIDTH  8  number of request slots; power of 2, >= 2
// PORTS
//  - CLK             in   1                 clock; all state updates on posedge
//  - nRST            in   1                 reset, asynchronous, active-low
//  - set_valid       in   1                 set_vec is valid this cycle
//  - set_vec         in   WIDTH             request bits to OR into pending vector
//  - flush           in   1                 synchronous clear of all pending bits
//  - lane0_valid     out  1                 >=1 pending bit exists
//  - lane0_one_hot   out  WIDTH             one-hot of lowest pending bit; 0 if none
//  - lane0_index     out  $clog2(WIDTH)     index of lowest pending bit; 0 if none
//  - lane0_ready     in   1                 consumer accepts lane0
//  - lane1_valid     out  1                 >=2 pending bits exist
//  - lane1_one_hot   out  WIDTH             one-hot of second-lowest pending bit; 0 if none
//  - lane1_index     out  $clog2(WIDTH)     index of second-lowest pending bit; 0 if none
//  - lane1_ready     in   1                 consumer accepts lane1
//  - pend_vec        out  WIDTH             current pending vector (registered)
//  - empty           out  1                 pend_vec == 0
// BEHAVIOUR
//  - State: pend_vec_q[WIDTH]. Reset value is 0. Reset is async, so on nRST low:
//    - all lane valids = 0, one_hots = 0, indices = 0
//    - pend_vec = 0, empty = 1
//  - All lane outputs are combinational from pend_vec_q only; no input-to-output combinational path.
//  - Latency: bits set in cycle N are visible on lane outputs in cycle N+1.
//  - Handshake:
//    - acc0 = lane0_valid & lane0_ready
//    - acc1 = lane1_valid & lane1_ready & lane0_ready
//    - lane1 never retires ahead of lane0; lane1_ready with lane0_ready=0 retires nothing.
//    - Valid/one_hot/index are held stable while not accepted and no new lower bit arrives.
//    - New set bits may reorder the lanes on the next cycle.
//  - Next state, priority high to low:
//    - flush=1: pend_next = 0 (set_vec is dropped that cycle).
//    - else: pend_next = (pend_q & ~(acc0 ? lane0_one_hot : 0) & ~(acc1 ? lane1_one_hot : 0)) | (set_valid ? set_vec : 0).
//  - Same-cycle set of a bit being retired: the set wins, the bit stays pending (re-armed request).
//  - Setting an already-pending bit has no effect (no counting/duplication).
//  - Full (all ones): lane0 = bit 0, lane1 = bit 1. Full drain of WIDTH bits takes WIDTH/2 cycles with both readys high.
//  - Single pending bit: lane1_valid=0, lane1_one_hot=0, lane1_index=0; lane1_ready is ignored.
//  - Reset mid-drain: pending bits are lost immediately. No handshake is reported in the reset cycle.
// CONFIGURATION
//  - PE2_REQ_DRAIN_PERF_EN defined:
//    - adds output perf_grant_cnt [15:0]: saturating count of accepted grants.
//    - Increments by acc0+acc1 (0/1/2) per cycle, sticks at 16'hFFFF.
//    - Reset value 0; flush does not clear it.
//  - Not defined: port and counter are absent; all other behaviour is identical.
// TESTING (WIDTH=8)
//  - Reset: nRST=0 with set_valid=1, set_vec=8'hFF.
//    -> pend_vec=0, empty=1, lane0/1_valid=0, one_hots=0, indices=0, asynchronously.
//  - Hold: set 8'b10100100 in cycle N, readys=0.
//    -> N+1..N+3: lane0 idx 2 (00000100), lane1 idx 5 (00100000); pend unchanged.
//  - Drain: from 8'b10100100, both readys=1.
//    -> next: pend=10000000, lane0 idx 7, lane1_valid=0.
//    -> next: empty=1. Perf build: perf_grant_cnt=3.
//  - Ordering: pend=00000011, lane0_ready=0, lane1_ready=1.
//    -> pend stays 00000011 and no grant is counted.
//  - Re-arm: pend=00000100, lane0_ready=1, set_vec=00000100 same cycle.
//    -> pend stays 00000100, lane0 idx 2 again.
//  - Flush: pend=11110000, flush=1 with set_valid=1, set_vec=00000001.
//    -> pend=0 next cycle, empty=1.

Source files
------------

// File: rtl/pe2_req_drain.sv
// Pending-request vector drained two-wide through lowest/second-lowest bit lanes.
// Define PE2_REQ_DRAIN_PERF_EN to add the saturating perf_grant_cnt output.
module pe2_req_drain #(
    parameter int WIDTH = 8,
    localparam int IW = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             set_valid,
    input  logic [WIDTH-1:0] set_vec,
    input  logic             flush,
    output logic             lane0_valid,
    output logic [WIDTH-1:0] lane0_one_hot,
    output logic [IW-1:0]    lane0_index,
    input  logic             lane0_ready,
    output logic             lane1_valid,
    output logic [WIDTH-1:0] lane1_one_hot,
    output logic [IW-1:0]    lane1_index,
    input  logic             lane1_ready,
    output logic [WIDTH-1:0] pend_vec,
    output logic             empty
`ifdef PE2_REQ_DRAIN_PERF_EN
    ,
    output logic [15:0]      perf_grant_cnt
`endif
);

    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] rest;
    logic             acc0, acc1;

    function automatic logic [IW-1:0] enc(input logic [WIDTH-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (oh[i]) r = r | IW'(i);
        end
        return r;
    endfunction

    // x & -x isolates the lowest set bit; apply twice for the second lane
    always_comb begin
        lane0_one_hot = pend_q & (~pend_q + WIDTH'(1));
        rest          = pend_q & ~lane0_one_hot;
        lane1_one_hot = rest & (~rest + WIDTH'(1));
        lane0_valid   = |pend_q;
        lane1_valid   = |rest;
        lane0_index   = enc(lane0_one_hot);
        lane1_index   = enc(lane1_one_hot);
        pend_vec      = pend_q;
        empty         = ~|pend_q;
    end

    always_comb begin
        acc0   = lane0_valid & lane0_ready;
        acc1   = lane1_valid & lane1_ready & lane0_ready;
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            pend_d = pend_q
                   & ~(acc0 ? lane0_one_hot : '0)
                   & ~(acc1 ? lane1_one_hot : '0);
            if (set_valid) pend_d = pend_d | set_vec;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) pend_q <= '0;
        else       pend_q <= pend_d;
    end

`ifdef PE2_REQ_DRAIN_PERF_EN
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_sum;

    always_comb begin
        cnt_sum = {1'b0, cnt_q} + 17'(acc0) + 17'(acc1);
        cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign perf_grant_cnt = cnt_q;
`endif

endmodule
